retire_trace_gen: RTL and testbench

- Producer side of the retire-trace interface used by the custom CPU simulation checker. Sits inside the custom CPU at the writeback stage.
- Collects register-writeback events from two writeback paths: port A (ALU/jump path) and port B (load/multi-cycle path).
- Filters out events that do not write a register, buffers the rest in a FIFO, and emits at most one 70-bit retire record per cycle on inst_retire in program order.
- Throttles the pipeline through retire_stall when the buffer nears full.

---
 rtl/retire_trace_if.sv | 36 +++
 rtl/retire_trace_gen.sv | 81 ++++++++
 tb/tb_retire_trace_gen.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_if.sv
// Retire-trace writeback bundle: two writeback ports in,
// one retire record, stall and status out.
interface retire_trace_if;
  logic        wba_valid;
  logic        wba_wen;
  logic [31:0] wba_pc;
  logic [4:0]  wba_waddr;
  logic [31:0] wba_wdata;
  logic        wbb_valid;
  logic        wbb_wen;
  logic [31:0] wbb_pc;
  logic [4:0]  wbb_waddr;
  logic [31:0] wbb_wdata;
  logic        retire_stall;
  logic [69:0] inst_retire;
  logic [31:0] retired_cnt;
  logic        overflow;

  modport master (
    output wba_valid, wba_wen, wba_pc,
    output wba_waddr, wba_wdata,
    output wbb_valid, wbb_wen, wbb_pc,
    output wbb_waddr, wbb_wdata,
    input  retire_stall, inst_retire,
    input  retired_cnt, overflow
  );

  modport slave (
    input  wba_valid, wba_wen, wba_pc,
    input  wba_waddr, wba_wdata,
    input  wbb_valid, wbb_wen, wbb_pc,
    input  wbb_waddr, wbb_wdata,
    output retire_stall, inst_retire,
    output retired_cnt, overflow
  );
endinterface

// File: rtl/retire_trace_gen.sv
// Writeback retire-trace producer: filters register writes,
// buffers them in order and emits one record per cycle.
module retire_trace_gen #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic            sys_clk,
  input  logic            sys_reset_n,
  retire_trace_if.slave   tr
);
  localparam int CW = PTR_W + 1;
  localparam int KW = PTR_W + 2;

  logic [68:0]    mem_q [DEPTH];
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] wr_a;
  logic [69:0]    out_q, out_d;
  logic [31:0]    ret_q, ret_d;
  logic           ovf_q, ovf_d;
  logic           pop;
  logic           push_a, push_b;
  logic           ok_a, ok_b;
  logic [KW-1:0]  cap;
  logic [68:0]    rec_a, rec_b;

  // Qualify pushes, apply capacity (B is older so it wins),
  // and form next state for pointers, count and output.
  always_comb begin
    pop    = cnt_q != '0;
    push_a = tr.wba_valid && tr.wba_wen
             && tr.wba_waddr != 5'd0;
    push_b = tr.wbb_valid && tr.wbb_wen
             && tr.wbb_waddr != 5'd0;
    rec_a  = {tr.wba_waddr, tr.wba_wdata, tr.wba_pc};
    rec_b  = {tr.wbb_waddr, tr.wbb_wdata, tr.wbb_pc};
    cap    = KW'(DEPTH) - KW'(cnt_q) + KW'(pop);
    ok_b   = push_b && cap != '0;
    ok_a   = push_a && (ok_b ? cap >= KW'(2)
                             : cap != '0);
    wr_a   = wr_q + PTR_W'(ok_b);
    wr_d   = wr_q + PTR_W'(ok_a) + PTR_W'(ok_b);
    rd_d   = rd_q + PTR_W'(pop);
    cnt_d  = cnt_q - CW'(pop) + CW'(ok_a) + CW'(ok_b);
    out_d  = pop ? {1'b1, mem_q[rd_q]} : '0;
    ret_d  = ret_q + 32'(pop);
    ovf_d  = ovf_q | (push_a & ~ok_a)
                   | (push_b & ~ok_b);
  end

  // Control state; reset drops all buffered entries.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      out_q <= '0;
      ret_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      out_q <= out_d;
      ret_q <= ret_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage: B lands first, A in the following slot.
  always_ff @(posedge sys_clk) begin
    if (ok_b) mem_q[wr_q] <= rec_b;
    if (ok_a) mem_q[wr_a] <= rec_a;
  end

  assign tr.retire_stall = cnt_q >= CW'(DEPTH - 2);
  assign tr.inst_retire  = out_q;
  assign tr.retired_cnt  = ret_q;
  assign tr.overflow     = ovf_q;
endmodule

// File: tb/tb_retire_trace_gen.sv
// Scoreboard bench for retire_trace_gen: a reference FIFO
// model predicts every record, count, stall and overflow.
module tb_retire_trace_gen;
  localparam int DEPTH = 8;

  logic sys_clk = 1'b0;
  logic sys_reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  logic [68:0] mq [$];
  logic [69:0] outq [$];
  logic [31:0] m_cnt = '0;
  logic        m_ovf = 1'b0;

  retire_trace_if tr ();

  retire_trace_gen #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .tr          (tr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [69:0] got,
                     input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    outq.delete();
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit pop;
    int cap;
    bit qa, qb;
    pop = mq.size() > 0;
    cap = DEPTH - mq.size() + int'(pop);
    if (pop) begin
      outq.push_back({1'b1, mq.pop_front()});
      m_cnt++;
    end
    qb = tr.wbb_valid && tr.wbb_wen && tr.wbb_waddr != 0;
    qa = tr.wba_valid && tr.wba_wen && tr.wba_waddr != 0;
    if (qb) begin
      if (cap > 0) begin
        mq.push_back({tr.wbb_waddr, tr.wbb_wdata, tr.wbb_pc});
        cap--;
      end else m_ovf = 1'b1;
    end
    if (qa) begin
      if (cap > 0) begin
        mq.push_back({tr.wba_waddr, tr.wba_wdata, tr.wba_pc});
        cap--;
      end else m_ovf = 1'b1;
    end
  endtask

  always @(negedge sys_clk) begin
    if (mon_en && sys_reset_n) begin
      if (outq.size() > 0)
        chk("record", tr.inst_retire, outq.pop_front());
      else
        chk("idle", tr.inst_retire, '0);
      chk("retired_cnt", tr.retired_cnt, m_cnt);
      chk("overflow", tr.overflow, m_ovf);
      chk("stall", tr.retire_stall, mq.size() >= DEPTH - 2);
    end
  end

  task automatic set_a(input logic v, input logic w,
                       input logic [31:0] pc,
                       input logic [4:0] ad,
                       input logic [31:0] d);
    tr.wba_valid = v;
    tr.wba_wen   = w;
    tr.wba_pc    = pc;
    tr.wba_waddr = ad;
    tr.wba_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic w,
                       input logic [31:0] pc,
                       input logic [4:0] ad,
                       input logic [31:0] d);
    tr.wbb_valid = v;
    tr.wbb_wen   = w;
    tr.wbb_pc    = pc;
    tr.wbb_waddr = ad;
    tr.wbb_wdata = d;
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    #2;
    sys_reset_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("rst_retire", tr.inst_retire, '0);
    chk("rst_cnt", tr.retired_cnt, '0);
    chk("rst_ovf", tr.overflow, '0);
    chk("rst_stall", tr.retire_stall, '0);
    model_clear();
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int nq;
    logic [31:0] pc;
    logic st;
    logic av, aw, bv, bw;
    logic [4:0] aa, ba;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    @(negedge sys_clk);
    do_reset();

    // 1: single push, one cycle residence
    set_a(1, 1, 32'hBFC0_0000, 5, 32'h1234);
    cyc();
    chk("t1_lat0", tr.inst_retire, '0);
    cyc();
    chk("t1_rec", tr.inst_retire,
        {1'b1, 5'd5, 32'h1234, 32'hBFC0_0000});
    cyc();
    chk("t1_after", tr.inst_retire, '0);
    chk("t1_cnt", tr.retired_cnt, 32'd1);

    // 2: filtering
    do_reset();
    set_a(1, 1, 32'h4, 0, 32'h99);
    cyc();
    set_b(1, 0, 32'h8, 7, 32'h55);
    cyc();
    set_a(1, 1, 32'h10, 3, 32'h7);
    cyc();
    idle(3);
    chk("t2_cnt", tr.retired_cnt, 32'd1);
    chk("t2_ovf", tr.overflow, 1'b0);

    // 3: dual push ordering
    do_reset();
    set_b(1, 1, 32'h20, 2, 32'hB);
    set_a(1, 1, 32'h24, 4, 32'hA);
    cyc();
    cyc();
    chk("t3_first", tr.inst_retire,
        {1'b1, 5'd2, 32'hB, 32'h20});
    cyc();
    chk("t3_second", tr.inst_retire,
        {1'b1, 5'd4, 32'hA, 32'h24});
    cyc();
    chk("t3_empty", tr.inst_retire, '0);
    chk("t3_stall", tr.retire_stall, 1'b0);

    // 4: dual pushes ignoring stall
    do_reset();
    pc = 32'h1000;
    for (int i = 0; i < 12; i++) begin
      set_b(1, 1, pc, 5'(i % 31 + 1), pc ^ 32'hF0);
      set_a(1, 1, pc + 4, 5'(i % 30 + 2), pc ^ 32'h0F);
      pc += 8;
      cyc();
    end
    chk("t4_stall", tr.retire_stall, 1'b1);
    idle(12);
    chk("t4_ovf", tr.overflow, 1'b1);

    // 5: random traffic honouring stall
    do_reset();
    nq = 0;
    pc = 32'h8000_0000;
    for (int i = 0; i < 1000; i++) begin
      st = tr.retire_stall;
      bv = ($urandom_range(0, 1) == 1) && !st;
      av = ($urandom_range(0, 1) == 1) && !st;
      bw = $urandom_range(0, 3) != 0;
      aw = $urandom_range(0, 3) != 0;
      ba = 5'($urandom_range(0, 31));
      aa = 5'($urandom_range(0, 31));
      set_b(bv, bw, pc, ba, $urandom);
      set_a(av, aw, pc + 4, aa, $urandom);
      if (bv && bw && ba != 0) nq++;
      if (av && aw && aa != 0) nq++;
      pc += 8;
      cyc();
    end
    idle(12);
    chk("t5_ovf", tr.overflow, 1'b0);
    chk("t5_cnt", tr.retired_cnt, 32'(nq));

    // 6: reset with entries buffered
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_b(1, 1, 32'h300 + 8 * i, 6, 32'(i));
      set_a(1, 1, 32'h304 + 8 * i, 9, 32'(i));
      cyc();
    end
    chk("t6_stall5", tr.retire_stall, 1'b0);
    do_reset();
    idle(10);
    chk("t6_cnt", tr.retired_cnt, '0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
